// File: rtl/vga_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vga_fetch_scheduler
// Brief    : Fetches frame words from SRAM into a pixel FIFO, yielding the
//            bus to the CPU with bounded bursts and request-free gaps.
// Revision : 1.0
// ============================================================================

module vga_fetch_scheduler #(
    parameter int FIFO_DEPTH   = 16,
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 4,
    parameter int GAP_CYCLES   = 1,
    parameter int FRAME_WORDS  = 38400
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_enable,
    input  logic [17:0] I_base_adr,
    input  logic        I_frame_start,
    input  logic        I_cpu_pending,
    output logic        O_vga_req,
    output logic [17:0] O_vga_adr,
    input  logic [15:0] I_vga_dat,
    output logic [15:0] O_pix_dat,
    output logic        O_pix_valid,
    input  logic        I_pix_pop,
    output logic [6:0]  O_level,
    output logic        O_underrun
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_BW = $clog2(MAX_BURST + 1);
    localparam int c_GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [7:0]      c_DEPTH       = 8'(FIFO_DEPTH);
    localparam logic [c_BW-1:0] c_MAX_BURST   = c_BW'(MAX_BURST);
    localparam logic [c_BW-1:0] c_BURST_LAST  = c_BW'(MAX_BURST - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST    = c_GW'(GAP_CYCLES - 1);
    localparam logic [17:0]     c_OFFSET_LAST = 18'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [17:0]       r_base;
    logic [17:0]       r_offset;
    logic [c_BW-1:0]   r_burst_cnt;
    logic [c_GW-1:0]   r_gap_cnt;
    logic [READ_LATENCY-1:0] r_tag;
    logic [6:0]        r_in_flight;
    logic [15:0]       r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW-1:0]   r_wr_ptr;
    logic [6:0]        r_level;
    logic              r_underrun;

    logic              w_issue;
    logic              w_push;
    logic              w_push_en;
    logic              w_pop_eff;
    logic [7:0]        w_resv;
    logic [7:0]        w_resv_next;
    logic              w_issue_now;
    logic              w_issue_next;
    logic              w_burst_done;
    logic              w_gap_done;

    // Reservation = words held plus words still in flight; never exceeds depth.
    assign w_issue      = (r_state == S_BURST);
    assign w_push       = r_tag[READ_LATENCY-1];
    assign w_push_en    = w_push && !I_reset && !I_frame_start;
    assign w_pop_eff    = I_pix_pop && (r_level != 7'd0);
    assign w_resv       = 8'(r_level) + 8'(r_in_flight);
    assign w_resv_next  = w_resv + 8'(w_issue) - 8'(w_pop_eff);
    assign w_issue_now  = I_enable && (w_resv < c_DEPTH);
    assign w_issue_next = I_enable && (w_resv_next < c_DEPTH);
    assign w_burst_done = (r_burst_cnt >= c_BURST_LAST);
    assign w_gap_done   = (r_gap_cnt == '0);

    // A finished gap takes the IDLE decision itself, so the bus sees exactly
    // GAP_CYCLES request-free cycles between bursts.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue_now) begin
                    w_state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (w_burst_done && I_cpu_pending) begin
                    w_state_next = S_GAP;
                end else if (!w_issue_next) begin
                    w_state_next = S_IDLE;
                end
            end
            S_GAP: begin
                if (w_gap_done) begin
                    w_state_next = w_issue_now ? S_BURST : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (I_frame_start) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_offset    <= '0;
            r_burst_cnt <= '0;
            r_gap_cnt   <= c_GAP_LAST;
            r_tag       <= '0;
            r_in_flight <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_level     <= '0;
            r_underrun  <= 1'b0;
        end else if (I_frame_start) begin
            r_state     <= S_IDLE;
            r_base      <= I_base_adr;
            r_offset    <= '0;
            r_burst_cnt <= '0;
            r_gap_cnt   <= c_GAP_LAST;
            r_tag       <= '0;
            r_in_flight <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_level     <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_issue) begin
                r_offset <= (r_offset == c_OFFSET_LAST) ? 18'd0 : r_offset + 18'd1;
            end

            if (w_state_next != S_BURST) begin
                r_burst_cnt <= '0;
            end else if (w_issue && (r_burst_cnt < c_MAX_BURST)) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end

            if (r_state != S_GAP) begin
                r_gap_cnt <= c_GAP_LAST;
            end else if (!w_gap_done) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end

            r_tag[0] <= w_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end

            r_in_flight <= r_in_flight + 7'(w_issue) - 7'(w_push);

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_eff) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + 7'(w_push) - 7'(w_pop_eff);

            if (I_pix_pop && (r_level == 7'd0)) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // Storage carries no reset; pointers and level define its contents.
    always_ff @(posedge I_clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr] <= I_vga_dat;
        end
    end

    assign O_vga_req   = w_issue;
    assign O_vga_adr   = r_base + r_offset;
    assign O_pix_dat   = r_mem[r_rd_ptr];
    assign O_pix_valid = (r_level != 7'd0);
    assign O_level     = r_level;
    assign O_underrun  = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_vga_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fetch_scheduler
// Brief    : Randomised self-checking bench with a queue-based reference model;
//            a second instance with an 8-word frame exercises address wrap.
// Revision : 1.0
// ============================================================================

module tb_vga_fetch_scheduler;

    localparam int c_DEPTH = 16;
    localparam int c_LAT   = 2;
    localparam int c_MB    = 4;
    localparam int c_GAP   = 1;
    localparam int c_FW_A  = 38400;
    localparam int c_FW_B  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, enable = 1'b0, frame_start = 1'b0, cpu_pending = 1'b0, pix_pop = 1'b0;
    logic [17:0] base_adr = '0;
    logic [15:0] dat_a = '0, dat_b = '0;

    logic        req_a, req_b, valid_a, valid_b, under_a, under_b;
    logic [17:0] adr_a, adr_b;
    logic [15:0] pix_a, pix_b;
    logic [6:0]  level_a, level_b;

    vga_fetch_scheduler u_dut (
        .I_clk(clk), .I_reset(rst), .I_enable(enable), .I_base_adr(base_adr),
        .I_frame_start(frame_start), .I_cpu_pending(cpu_pending),
        .O_vga_req(req_a), .O_vga_adr(adr_a), .I_vga_dat(dat_a),
        .O_pix_dat(pix_a), .O_pix_valid(valid_a), .I_pix_pop(pix_pop),
        .O_level(level_a), .O_underrun(under_a)
    );

    vga_fetch_scheduler #(
        .FIFO_DEPTH(c_DEPTH), .READ_LATENCY(c_LAT), .MAX_BURST(c_MB),
        .GAP_CYCLES(c_GAP), .FRAME_WORDS(c_FW_B)
    ) u_dut_wrap (
        .I_clk(clk), .I_reset(rst), .I_enable(enable), .I_base_adr(base_adr),
        .I_frame_start(frame_start), .I_cpu_pending(cpu_pending),
        .O_vga_req(req_b), .O_vga_adr(adr_b), .I_vga_dat(dat_b),
        .O_pix_dat(pix_b), .O_pix_valid(valid_b), .I_pix_pop(pix_pop),
        .O_level(level_b), .O_underrun(under_b)
    );

    typedef struct { logic [17:0] adr_a; logic [17:0] adr_b; int due; } item_t;
    typedef struct { logic [17:0] adr; int due; } sram_t;

    // Reference model: words in flight and words buffered, plus burst bookkeeping.
    item_t       m_fifo[$];
    item_t       m_infl[$];
    logic [17:0] m_base = '0;
    int          m_issues = 0;
    bit          m_bursting = 1'b0;
    int          m_run = 0;
    int          m_gap = 0;
    bit          m_under = 1'b0;
    bit          m_known = 1'b0;

    sram_t       q_a[$];
    sram_t       q_b[$];
    bit          req_hist[$];
    logic [17:0] adra_hist[$];
    logic [17:0] adrb_hist[$];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int n_popped = 0;

    function automatic logic [15:0] f_dat(input logic [17:0] a);
        logic [31:0] t;
        t = {14'd0, a} * 32'd40503 + 32'h1234;
        return t[15:0] ^ t[31:16];
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step(input bit r, input bit fs, input bit en, input bit cpu,
                              input bit pop, input logic [17:0] base);
        int resv_now;
        int resv_next;
        item_t it;
        if (r) begin
            m_fifo.delete(); m_infl.delete();
            m_base = '0; m_issues = 0; m_bursting = 1'b0;
            m_run = 0; m_gap = 0; m_under = 1'b0; m_known = 1'b1;
        end else if (fs) begin
            m_fifo.delete(); m_infl.delete();
            m_base = base; m_issues = 0; m_bursting = 1'b0; m_run = 0; m_gap = 0;
        end else begin
            resv_now = m_fifo.size() + m_infl.size();
            if (pop) begin
                if (m_fifo.size() > 0) m_fifo.delete(0);
                else m_under = 1'b1;
            end
            if (m_infl.size() > 0 && m_infl[0].due == cyc) begin
                m_fifo.push_back(m_infl[0]);
                m_infl.delete(0);
            end
            if (m_bursting) begin
                it.adr_a = m_base + 18'(m_issues % c_FW_A);
                it.adr_b = m_base + 18'(m_issues % c_FW_B);
                it.due   = cyc + c_LAT;
                m_infl.push_back(it);
                m_issues++;
            end
            resv_next = m_fifo.size() + m_infl.size();
            if (m_bursting) begin
                m_run++;
                if (m_run >= c_MB && cpu) begin
                    m_bursting = 1'b0; m_run = 0; m_gap = c_GAP;
                end else if (!(en && resv_next < c_DEPTH)) begin
                    m_bursting = 1'b0; m_run = 0;
                end
            end else if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0 && en && resv_now < c_DEPTH) m_bursting = 1'b1;
            end else if (en && resv_now < c_DEPTH) begin
                m_bursting = 1'b1;
            end
        end
    endtask

    task automatic run_cycle(input bit r, input bit fs, input bit en, input bit cpu,
                             input bit pop, input logic [17:0] base);
        logic [17:0] ea;
        logic [17:0] eb;
        @(negedge clk);
        rst = r; frame_start = fs; enable = en; cpu_pending = cpu; pix_pop = pop; base_adr = base;
        dat_a = 16'($urandom);
        dat_b = 16'($urandom);
        if (q_a.size() > 0 && q_a[0].due == cyc) begin dat_a = f_dat(q_a[0].adr); q_a.delete(0); end
        if (q_b.size() > 0 && q_b[0].due == cyc) begin dat_b = f_dat(q_b[0].adr); q_b.delete(0); end
        #1;
        if (m_known) begin
            ea = m_base + 18'(m_issues % c_FW_A);
            eb = m_base + 18'(m_issues % c_FW_B);
            check_val("req_a", 32'(req_a), 32'(m_bursting));
            check_val("req_b", 32'(req_b), 32'(m_bursting));
            if (m_bursting) begin
                check_val("adr_a", 32'(adr_a), 32'(ea));
                check_val("adr_b", 32'(adr_b), 32'(eb));
            end
            check_val("level_a", 32'(level_a), 32'(m_fifo.size()));
            check_val("level_b", 32'(level_b), 32'(m_fifo.size()));
            check_val("valid_a", 32'(valid_a), 32'(m_fifo.size() != 0));
            check_val("under_a", 32'(under_a), 32'(m_under));
            if (m_fifo.size() > 0) begin
                check_val("pix_a", 32'(pix_a), 32'(f_dat(m_fifo[0].adr_a)));
                check_val("pix_b", 32'(pix_b), 32'(f_dat(m_fifo[0].adr_b)));
            end
        end
        req_hist.push_back(req_a);
        if (req_a) begin q_a.push_back('{adr_a, cyc + c_LAT}); adra_hist.push_back(adr_a); end
        if (req_b) begin q_b.push_back('{adr_b, cyc + c_LAT}); adrb_hist.push_back(adr_b); end
        if (pop && valid_a) n_popped++;
        model_step(r, fs, en, cpu, pop, base);
        cyc++;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int h0;
        int n0;
        int idx;
        logic [9:0] pat;
        int pop_pct;

        // Reset state
        repeat (2) run_cycle(1, 0, 0, 0, 0, 18'h0);
        settle();
        check_val("rst_level", 32'(level_a), 32'd0);
        check_val("rst_valid", 32'(valid_a), 32'd0);
        check_val("rst_req",   32'(req_a),   32'd0);
        check_val("rst_under", 32'(under_a), 32'd0);

        // Fill with no CPU traffic and no pops
        run_cycle(0, 1, 1, 0, 0, 18'h100);
        h0 = adra_hist.size();
        repeat (30) run_cycle(0, 0, 1, 0, 0, 18'h0);
        check_val("fill_reqs", 32'(adra_hist.size() - h0), 32'd16);
        if (adra_hist.size() >= h0 + 16) begin
            check_val("fill_first", 32'(adra_hist[h0]), 32'h100);
            check_val("fill_last",  32'(adra_hist[h0 + 15]), 32'h10F);
        end
        settle();
        check_val("fill_level", 32'(level_a), 32'd16);
        check_val("fill_idle",  32'(req_a), 32'd0);

        // Streaming: pop every cycle once full
        n_popped = 0;
        repeat (60) run_cycle(0, 0, 1, 0, 1, 18'h0);
        check_val("stream_pops", 32'(n_popped), 32'd60);
        settle();
        check_val("stream_under", 32'(under_a), 32'd0);

        // Fairness: CPU pending throughout
        run_cycle(1, 0, 0, 0, 0, 18'h0);
        run_cycle(0, 1, 1, 1, 0, 18'h200);
        h0 = req_hist.size();
        repeat (30) run_cycle(0, 0, 1, 1, 0, 18'h0);
        idx = h0;
        while (idx < req_hist.size() && !req_hist[idx]) idx++;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            if (idx + i < req_hist.size()) pat[9 - i] = req_hist[idx + i];
        end
        check_val("fair_pattern", 32'(pat), 32'(10'b1111011110));

        // Wrap on the 8-word frame instance
        run_cycle(1, 0, 0, 0, 0, 18'h0);
        run_cycle(0, 1, 1, 0, 0, 18'h20);
        h0 = adrb_hist.size();
        repeat (12) run_cycle(0, 0, 1, 0, 0, 18'h0);
        check_val("wrap_cnt", 32'(adrb_hist.size() - h0 >= 9), 32'd1);
        if (adrb_hist.size() >= h0 + 9) begin
            check_val("wrap_first", 32'(adrb_hist[h0]), 32'h20);
            check_val("wrap_last",  32'(adrb_hist[h0 + 7]), 32'h27);
            check_val("wrap_again", 32'(adrb_hist[h0 + 8]), 32'h20);
        end

        // Flush two cycles into a burst
        run_cycle(1, 0, 0, 0, 0, 18'h0);
        run_cycle(0, 1, 1, 0, 0, 18'h0);
        run_cycle(0, 0, 1, 0, 0, 18'h0);
        run_cycle(0, 0, 1, 0, 0, 18'h0);
        run_cycle(0, 0, 1, 0, 0, 18'h0);
        run_cycle(0, 1, 1, 0, 0, 18'h300);
        n0 = adra_hist.size();
        settle();
        check_val("flush_level0", 32'(level_a), 32'd0);
        run_cycle(0, 0, 1, 0, 0, 18'h0);
        settle();
        check_val("flush_level1", 32'(level_a), 32'd0);
        repeat (10) run_cycle(0, 0, 1, 0, 0, 18'h0);
        check_val("flush_more", 32'(adra_hist.size() > n0), 32'd1);
        if (adra_hist.size() > n0) check_val("flush_adr", 32'(adra_hist[n0]), 32'h300);

        // Underrun: sticky until reset
        run_cycle(1, 0, 0, 0, 0, 18'h0);
        run_cycle(0, 0, 0, 0, 1, 18'h0);
        settle();
        check_val("under_set", 32'(under_a), 32'd1);
        check_val("under_lvl", 32'(level_a), 32'd0);
        repeat (4) run_cycle(0, 0, 0, 0, 0, 18'h0);
        run_cycle(0, 1, 0, 0, 0, 18'h40);
        settle();
        check_val("under_held", 32'(under_a), 32'd1);
        run_cycle(1, 0, 0, 0, 0, 18'h0);
        settle();
        check_val("under_clr", 32'(under_a), 32'd0);

        // Random traffic with occasional resets and frame restarts
        run_cycle(0, 1, 1, 0, 0, 18'h3FFF0);
        pop_pct = 50;
        for (int n = 0; n < 4000; n++) begin
            if (n % 400 == 0) pop_pct = 25 * int'($urandom_range(0, 4));
            run_cycle($urandom_range(0, 499) == 0,
                      $urandom_range(0, 99) == 0,
                      $urandom_range(0, 9) != 0,
                      $urandom_range(0, 1) == 1,
                      int'($urandom_range(1, 100)) <= pop_pct,
                      18'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
